// File: rtl/cla_sub_seq.sv
// cla_sub_seq: multi-cycle wide subtractor, d = a - b - bin.
// One SLICE-bit carry-lookahead slice is evaluated per clock, least
// significant slice first. The subtraction is done as a + ~b + ~bin, so the
// inter-slice carry means "no borrow". Valid/ready handshakes on both sides.
module cla_sub_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int N   = WIDTH / SLICE;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic [WIDTH-1:0]  d_r;
  logic              carry_r;
  logic [CW-1:0]     cnt_r;
  logic              in_ready_r;
  logic              out_valid_r;
  logic              bout_r;
  logic              ovf_r;
  logic              zero_r;

  logic [SLICE-1:0]  x_s;
  logic [SLICE-1:0]  y_s;
  logic [SLICE-1:0]  g_s;
  logic [SLICE-1:0]  p_s;
  logic [SLICE:0]    c_s;
  logic [SLICE-1:0]  sum_s;
  logic [WIDTH-1:0]  d_next_s;
  logic              last_s;

  // Slice operand select and per-bit generate/propagate for the current slice.
  always_comb begin
    x_s = a_r[cnt_r*SLICE +: SLICE];
    y_s = ~b_r[cnt_r*SLICE +: SLICE];
    g_s = x_s & y_s;
    p_s = x_s ^ y_s;
  end

  // Lookahead carries: each c[j+1] is a flat sum of products of g/p and the
  // slice carry-in, so no carry ripples through another carry in the slice.
  always_comb begin
    logic cy;
    logic term;
    cy     = 1'b0;
    term   = 1'b0;
    c_s    = '0;
    c_s[0] = carry_r;
    for (int j = 0; j < SLICE; j++) begin
      cy = carry_r;
      for (int k = 0; k <= j; k++) begin
        cy = cy & p_s[k];
      end
      for (int m = 0; m <= j; m++) begin
        term = g_s[m];
        for (int k = m + 1; k <= j; k++) begin
          term = term & p_s[k];
        end
        cy = cy | term;
      end
      c_s[j+1] = cy;
    end
  end

  // Slice sum merged into the running difference; flags are taken from this.
  always_comb begin
    sum_s    = p_s ^ c_s[SLICE-1:0];
    d_next_s = d_r;
    d_next_s[cnt_r*SLICE +: SLICE] = sum_s;
    last_s   = (cnt_r == CW'(N - 1));
  end

  // Control FSM, operand capture, slice accumulation and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      d_r         <= '0;
      carry_r     <= 1'b0;
      cnt_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      bout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      zero_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            a_r        <= a;
            b_r        <= b;
            carry_r    <= ~bin;
            cnt_r      <= '0;
            in_ready_r <= 1'b0;
            state_r    <= BUSY;
          end
        end
        BUSY: begin
          d_r     <= d_next_s;
          carry_r <= c_s[SLICE];
          cnt_r   <= cnt_r + CW'(1);
          if (last_s) begin
            state_r     <= DONE;
            out_valid_r <= 1'b1;
            bout_r      <= ~c_s[SLICE];
            ovf_r       <= (a_r[MSB] != b_r[MSB]) & (d_next_s[MSB] != a_r[MSB]);
            zero_r      <= (d_next_s == '0);
          end
        end
        DONE: begin
          // in_valid is ignored here; a new operand waits for IDLE.
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign d         = d_r;
  assign bout      = bout_r;
  assign ovf       = ovf_r;
  assign zero      = zero_r;

endmodule

// File: tb/tb_cla_sub_seq.sv
// Self-checking bench for cla_sub_seq (WIDTH=16, SLICE=4): directed vector
// table, backpressure and reset-abort sequences, and random traffic checked
// through a scoreboard queue against an arithmetic reference model.
module tb_cla_sub_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = 16'h0000;
  logic [15:0] b = 16'h0000;
  logic        bin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] d;
  logic        bout;
  logic        ovf;
  logic        zero;

  int nvec = 0;
  int nmis = 0;
  int npush = 0;
  int npop = 0;
  int rdy_mode = 0;   // 0: always ready, 1: random, 2: held low

  typedef struct packed {
    logic [15:0] d;
    logic        bout;
    logic        ovf;
    logic        zero;
  } exp_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] d;
    logic        bout;
    logic        ovf;
    logic        zero;
  } vec_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  cla_sub_seq #(.WIDTH(16), .SLICE(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout),
    .ovf       (ovf),
    .zero      (zero)
  );

  // Consumer readiness, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb, input logic mbin);
    exp_t        e;
    logic [16:0] full;
    int          sa;
    int          sb;
    int          sd;
    full   = {1'b0, ma} - {1'b0, mb} - {16'h0000, mbin};
    sa     = $signed(ma);
    sb     = $signed(mb);
    sd     = sa - sb - (mbin ? 1 : 0);
    e.d    = full[15:0];
    e.bout = full[16];
    e.ovf  = (sd > 32767) || (sd < -32768);
    e.zero = (full[15:0] == 16'h0000);
    return e;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    nvec++;
    nmis++;
    $display("FAIL %s: bound expired", nm);
  endtask

  // Scoreboard: a handshake happens on the next edge when both are high here.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      exp_t e;
      if (sbq.size() == 0) begin
        fail_now("unexpected result");
      end else begin
        e = sbq.pop_front();
        npop++;
        check("result d", {16'h0000, d}, {16'h0000, e.d});
        check("result bout", {31'd0, bout}, {31'd0, e.bout});
        check("result ovf", {31'd0, ovf}, {31'd0, e.ovf});
        check("result zero", {31'd0, zero}, {31'd0, e.zero});
      end
    end
  end

  // Offer an operand, wait for acceptance, then scramble inputs.
  task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tbin,
                      input bit push, input exp_t e);
    int g;
    g = 0;
    @(negedge clk);
    in_valid = 1'b1;
    a = ta;
    b = tb;
    bin = tbin;
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) begin
      fail_now("accept timeout");
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      if (push) begin
        sbq.push_back(e);
        npush++;
      end
      #1;
      in_valid = 1'b0;
      a = 16'($urandom);
      b = 16'($urandom);
      bin = 1'($urandom);
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((sbq.size() != 0 || !in_ready) && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (g >= 300) fail_now("drain timeout");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   lat;
    int   g;
    exp_t e;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rbin;

    vecs[0] = '{16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{16'h5555, 16'h5554, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};

    // Reset state, during and after reset.
    repeat (3) @(negedge clk);
    check("rst in_ready", {31'd0, in_ready}, 32'd1);
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post-rst in_ready", {31'd0, in_ready}, 32'd1);
    check("post-rst out_valid", {31'd0, out_valid}, 32'd0);
    check("post-rst d", {16'h0000, d}, 32'd0);
    check("post-rst flags", {29'd0, bout, ovf, zero}, 32'd0);

    // Directed table with latency and in_ready checks.
    for (int i = 0; i < 6; i++) begin
      e = '{vecs[i].d, vecs[i].bout, vecs[i].ovf, vecs[i].zero};
      send(vecs[i].a, vecs[i].b, vecs[i].bin, 1'b1, e);
      check("in_ready after accept", {31'd0, in_ready}, 32'd0);
      lat = 0;
      do begin
        @(posedge clk);
        #1;
        lat++;
        if (!out_valid) check("in_ready busy", {31'd0, in_ready}, 32'd0);
      end while (!out_valid && lat < 20);
      check("latency", lat, 32'd4);
      check("in_ready done", {31'd0, in_ready}, 32'd0);
      drain();
    end

    // Backpressure: result held, new operand refused until back in IDLE.
    rdy_mode = 2;
    send(16'h0100, 16'h0001, 1'b0, 1'b1, model(16'h0100, 16'h0001, 1'b0));
    g = 0;
    while (!out_valid && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (g >= 20) fail_now("backpressure wait");
    in_valid = 1'b1;
    a = 16'h0003;
    b = 16'h0001;
    bin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp out_valid", {31'd0, out_valid}, 32'd1);
      check("bp in_ready", {31'd0, in_ready}, 32'd0);
      check("bp d", {16'h0000, d}, 32'h0000_00FF);
      check("bp flags", {29'd0, bout, ovf, zero}, 32'd0);
      @(negedge clk);
    end
    rdy_mode = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("bp idle out_valid", {31'd0, out_valid}, 32'd0);
    check("bp idle in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    check("bp pending accepted", {31'd0, in_ready}, 32'd0);
    sbq.push_back(model(16'h0003, 16'h0001, 1'b0));
    npush++;
    in_valid = 1'b0;
    drain();

    // Reset abort after two busy cycles.
    send(16'h1234, 16'h0001, 1'b0, 1'b0, '0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort out_valid", {31'd0, out_valid}, 32'd0);
    check("abort d", {16'h0000, d}, 32'd0);
    check("abort flags", {29'd0, bout, ovf, zero}, 32'd0);
    check("abort in_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(16'h00FF, 16'h00FF, 1'b0, 1'b1, '{16'h0000, 1'b0, 1'b0, 1'b1});
    drain();

    // Random back-to-back traffic with random consumer readiness.
    rdy_mode = 1;
    for (int i = 0; i < 5000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rbin = 1'($urandom);
      if ((i % 7) == 0) ra = 16'h8000;
      if ((i % 11) == 0) rb = 16'hFFFF;
      if ((i % 13) == 0) rb = ra;
      send(ra, rb, rbin, 1'b1, model(ra, rb, rbin));
    end
    drain();
    rdy_mode = 0;
    repeat (3) @(negedge clk);

    check("scoreboard empty", sbq.size(), 32'd0);
    check("result count", npop, npush);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
